// File: rtl/load_index_control.sv
`default_nettype none
// ============================================================================
// Module   : load_index_control
// Brief    : Moore sequencer for ld Ra, C(Rb); drives the single-bus datapath
//            strobes through fetch and execute and waits on mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
module load_index_control #(
  parameter logic [4:0]  LD_OPCODE   = 5'b00000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       mem_ready,
  input  logic [4:0] ir_opcode,
  output logic       pco,
  output logic       mari,
  output logic       mem_read,
  output logic       mdri,
  output logic       mdro,
  output logic       iri,
  output logic       grb,
  output logic       gra,
  output logic       baout,
  output logic       rin,
  output logic       ryi,
  output logic       csigno,
  output logic       rzli,
  output logic       rzlo,
  output logic       busy,
  output logic       done,
  output logic [1:0] fault
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_T8    = 4'd9,
    S_T9    = 4'd10,
    S_T10   = 4'd11,
    S_FAULT = 4'd12
  } state_t;

  localparam logic [1:0] c_fault_none    = 2'b00;
  localparam logic [1:0] c_fault_timeout = 2'b01;
  localparam logic [1:0] c_fault_opcode  = 2'b10;
  // Count value seen on the edge that would bring the counter to MEM_TIMEOUT.
  localparam logic [7:0] c_wait_last     = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [1:0] r_fault;
  logic [1:0] w_fault_next;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_fault <= c_fault_none;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_fault <= w_fault_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_fault_next = r_fault;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next       = S_T0;
          w_fault_next = c_fault_none;
        end
      end
      S_T0: begin
        w_next     = S_T1;
        w_cnt_next = 8'd0;
      end
      S_T1, S_T8: begin
        // mem_ready wins over a timeout landing on the same edge.
        if (mem_ready) begin
          w_next = (r_state == S_T1) ? S_T2 : S_T9;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
          if (r_cnt == c_wait_last) begin
            w_next       = S_FAULT;
            w_fault_next = c_fault_timeout;
          end
        end
      end
      S_T2: w_next = S_T3;
      S_T3: w_next = S_T4;
      S_T4: begin
        if (ir_opcode == LD_OPCODE) begin
          w_next = S_T5;
        end else begin
          w_next       = S_FAULT;
          w_fault_next = c_fault_opcode;
        end
      end
      S_T5: w_next = S_T6;
      S_T6: w_next = S_T7;
      S_T7: begin
        w_next     = S_T8;
        w_cnt_next = 8'd0;
      end
      S_T9:    w_next = S_T10;
      S_T10:   w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pco      = 1'b0;
    mari     = 1'b0;
    mem_read = 1'b0;
    mdri     = 1'b0;
    mdro     = 1'b0;
    iri      = 1'b0;
    grb      = 1'b0;
    gra      = 1'b0;
    baout    = 1'b0;
    rin      = 1'b0;
    ryi      = 1'b0;
    csigno   = 1'b0;
    rzli     = 1'b0;
    rzlo     = 1'b0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_T0: begin
        pco  = 1'b1;
        mari = 1'b1;
      end
      S_T1, S_T8: mem_read = 1'b1;
      S_T2, S_T9: begin
        mem_read = 1'b1;
        mdri     = 1'b1;
      end
      S_T3: begin
        mdro = 1'b1;
        iri  = 1'b1;
      end
      S_T5: begin
        grb   = 1'b1;
        baout = 1'b1;
        ryi   = 1'b1;
      end
      S_T6: begin
        csigno = 1'b1;
        rzli   = 1'b1;
      end
      S_T7: begin
        rzlo = 1'b1;
        mari = 1'b1;
      end
      S_T10: begin
        mdro = 1'b1;
        gra  = 1'b1;
        rin  = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_index_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_load_index_control
// Brief    : Self-checking bench with a small single-bus datapath model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_index_control;

  localparam int TO = 15;
  localparam int ST_IDLE = 0, ST_T0 = 1, ST_T1 = 2, ST_T2 = 3, ST_T3 = 4, ST_T4 = 5,
                 ST_T5 = 6, ST_T6 = 7, ST_T7 = 8, ST_T8 = 9, ST_T9 = 10, ST_T10 = 11,
                 ST_FAULT = 12;

  logic clock = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic mem_ready = 1'b0;
  logic [4:0] ir_opcode;
  logic pco, mari, mem_read, mdri, mdro, iri, grb, gra, baout, rin, ryi, csigno, rzli, rzlo;
  logic busy, done;
  logic [1:0] fault;

  load_index_control #(.LD_OPCODE(5'b00000), .MEM_TIMEOUT(TO)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready),
    .ir_opcode(ir_opcode),
    .pco(pco), .mari(mari), .mem_read(mem_read), .mdri(mdri), .mdro(mdro), .iri(iri),
    .grb(grb), .gra(gra), .baout(baout), .rin(rin), .ryi(ryi), .csigno(csigno),
    .rzli(rzli), .rzlo(rzlo), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  // ---------------- datapath model ----------------
  logic [31:0] mem [0:255];
  logic [31:0] regs [0:15];
  logic [31:0] mar, mdr, ir, y, z, bus;
  logic        preload = 1'b0;
  logic [3:0]  pl_rb;
  logic [31:0] pl_val;
  logic [3:0]  ra_f, rb_f;

  assign ra_f = ir[26:23];
  assign rb_f = ir[22:19];
  assign ir_opcode = ir[31:27];

  always_comb begin
    bus = 32'h0;
    if (pco) bus = 32'h0;
    if (mdro) bus = mdr;
    if (rzlo) bus = z;
    if (csigno) bus = {{13{ir[18]}}, ir[18:0]};
    if (grb && baout) bus = (rb_f == 4'd0) ? 32'h0 : regs[rb_f];
  end

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
      regs[pl_rb] <= pl_val;
    end else if (rin && gra) begin
      regs[ra_f] <= bus;
    end
    if (mari) mar <= bus;
    if (mdri && mem_read) mdr <= mem[mar[7:0]];
    if (iri) ir <= bus;
    if (ryi) y <= bus;
    if (rzli) z <= y + bus;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [15:0] dut_vec;
  assign dut_vec = {pco, mari, mem_read, mdri, mdro, iri, grb, gra, baout, rin, ryi,
                    csigno, rzli, rzlo, busy, done};

  function automatic logic [15:0] vec_of(input int st);
    logic [15:0] v;
    v = 16'h0;
    case (st)
      ST_T0:          v = 16'b1100_0000_0000_0010;
      ST_T1, ST_T8:   v = 16'b0010_0000_0000_0010;
      ST_T2, ST_T9:   v = 16'b0011_0000_0000_0010;
      ST_T3:          v = 16'b0000_1100_0000_0010;
      ST_T4:          v = 16'b0000_0000_0000_0010;
      ST_T5:          v = 16'b0000_0010_1010_0010;
      ST_T6:          v = 16'b0000_0000_0001_1010;
      ST_T7:          v = 16'b0100_0000_0000_0110;
      ST_T10:         v = 16'b0000_1001_0100_0011;
      ST_FAULT:       v = 16'b0000_0000_0000_0010;
      default:        v = 16'h0;
    endcase
    return v;
  endfunction

  typedef struct {
    int         st;
    logic       rdy;
    logic [1:0] flt;
  } item_t;

  item_t sb[$];

  task automatic push(input int st, input logic rdy, input logic [1:0] flt);
    item_t it;
    it.st = st; it.rdy = rdy; it.flt = flt;
    sb.push_back(it);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [3:0]  ra, rb;
    logic [31:0] rb_val;
    logic [18:0] c;
    logic [7:0]  addr;
    logic [31:0] data;
    int          w1, w8;
    bit          hold;
    logic [1:0]  exp_fault;
    int          exp_done;
  } case_t;

  // Expected cycle-by-cycle schedule derived from the state list.
  task automatic build(input case_t tc);
    logic r;
    sb.delete();
    push(ST_T0, 1'($urandom_range(0, 1)), 2'b00);
    if (tc.w1 >= TO) begin
      for (int i = 0; i < TO; i++) push(ST_T1, 1'b0, 2'b00);
      push(ST_FAULT, 1'b1, 2'b01);
      push(ST_IDLE, 1'b0, 2'b01);
      return;
    end
    for (int i = 0; i < tc.w1; i++) push(ST_T1, 1'b0, 2'b00);
    push(ST_T1, 1'b1, 2'b00);
    for (int s = ST_T2; s <= ST_T4; s++) begin
      r = 1'($urandom_range(0, 1));
      push(s, r, 2'b00);
    end
    if (tc.op != 5'b00000) begin
      push(ST_FAULT, 1'b1, 2'b10);
      push(ST_IDLE, 1'b0, 2'b10);
      return;
    end
    for (int s = ST_T5; s <= ST_T7; s++) push(s, 1'($urandom_range(0, 1)), 2'b00);
    for (int i = 0; i < tc.w8; i++) push(ST_T8, 1'b0, 2'b00);
    push(ST_T8, 1'b1, 2'b00);
    push(ST_T9, 1'b0, 2'b00);
    push(ST_T10, 1'b1, 2'b00);
    push(ST_IDLE, 1'b1, 2'b00);
  endtask

  task automatic run_case(input case_t tc);
    item_t it;
    int cyc, done_at;
    bit  faulted;
    mem[0]       = {tc.op, tc.ra, tc.rb, tc.c};
    mem[tc.addr] = tc.data;
    pl_rb   = tc.rb;
    pl_val  = tc.rb_val;
    build(tc);
    preload = 1'b1;
    start   = 1'b1;
    @(posedge clock); #1;
    preload = 1'b0;
    if (!tc.hold) start = 1'b0;
    cyc = 0;
    done_at = -1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      cyc++;
      chk($sformatf("%s strobes c%0d", tc.name, cyc), 32'(dut_vec), 32'(vec_of(it.st)));
      chk($sformatf("%s fault c%0d", tc.name, cyc), 32'(fault), 32'(it.flt));
      if (done === 1'b1) done_at = cyc;
      mem_ready = it.rdy;
      if (tc.hold && (it.st == ST_T10 || it.st == ST_FAULT)) start = 1'b0;
      if (sb.size() > 0) begin
        @(posedge clock); #1;
      end
    end
    faulted = (tc.exp_fault != 2'b00);
    chk({tc.name, " done_cycle"}, 32'(done_at), 32'(tc.exp_done));
    chk({tc.name, " final_fault"}, 32'(fault), 32'(tc.exp_fault));
    chk({tc.name, " reg_ra"}, regs[tc.ra], faulted ? 32'h0 : tc.data);
    chk({tc.name, " mar"}, mar, faulted ? 32'h0 : 32'(tc.addr));
  endtask

  case_t cases[8];
  case_t tc_norm;

  initial begin
    //          name       op      ra    rb    rb_val        c          addr   data          w1  w8  hold fault  done
    cases[0] = '{"normal",  5'd0,  4'd2, 4'd1, 32'h20,  19'h00010, 8'h30, 32'hDEADBEEF,  0,  0, 0, 2'b00, 11};
    cases[1] = '{"timeout", 5'd0,  4'd2, 4'd1, 32'h20,  19'h00010, 8'h30, 32'h11111111, TO,  0, 0, 2'b01, -1};
    cases[2] = '{"r0base",  5'd0,  4'd3, 4'd0, 32'h55,  19'h0007C, 8'h7C, 32'h00001234,  0,  0, 0, 2'b00, 11};
    cases[3] = '{"negoff",  5'd0,  4'd4, 4'd5, 32'h40,  19'h7FFFC, 8'h3C, 32'hCAFEF00D,  0,  3, 0, 2'b00, 14};
    cases[4] = '{"wait_t1", 5'd0,  4'd6, 4'd7, 32'h10,  19'h00005, 8'h15, 32'h0BADF00D,  2,  0, 0, 2'b00, 13};
    cases[5] = '{"illegal", 5'd2,  4'd8, 4'd9, 32'h40,  19'h00001, 8'h41, 32'h22222222,  0,  0, 0, 2'b10, -1};
    cases[6] = '{"hold",    5'd0,  4'd1, 4'd2, 32'h80,  19'h00002, 8'h82, 32'h5A5A5A5A,  0,  0, 1, 2'b00, 11};
    cases[7] = '{"prio",    5'd0,  4'd5, 4'd6, 32'h90,  19'h00003, 8'h93, 32'hA5A5A5A5,  0, 14, 0, 2'b00, 25};
    tc_norm  = cases[0];

    mem_ready = 1'b1;
    #1;
    chk("reset strobes", 32'(dut_vec), 32'h0);
    chk("reset fault", 32'(fault), 32'h0);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("idle strobes", 32'(dut_vec), 32'h0);

    for (int i = 0; i < 8; i++) run_case(cases[i]);

    // Asynchronous reset during T6, then a clean run.
    mem[0] = {tc_norm.op, tc_norm.ra, tc_norm.rb, tc_norm.c};
    pl_rb = tc_norm.rb; pl_val = tc_norm.rb_val;
    preload = 1'b1; start = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    preload = 1'b0; start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("mid T6 strobes", 32'(dut_vec), 32'(vec_of(ST_T6)));
    #2 clear = 1'b0;
    #1;
    chk("async reset strobes", 32'(dut_vec), 32'h0);
    chk("async reset fault", 32'(fault), 32'h0);
    start = 1'b1;
    @(posedge clock); #1;
    chk("start in reset", 32'(dut_vec), 32'h0);
    start = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("post reset idle", 32'(dut_vec), 32'h0);
    run_case(tc_norm);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_index_control.md
# load_index_control

Control-unit sequencer for the indexed load `ld Ra, C(Rb)`: Ra <- M[Rb + sign_ext(C)], with Rb = R0 meaning absolute address C. It is the read-side counterpart of the store-indexed sequence. It drives the same single-bus datapath strobes (MAR/MDR, IR, Y, Z, register-file select) through the fetch and execute phases, and handshakes with memory through `mem_ready`. It sits between the instruction issue logic and `datapath`, and replaces hand-sequenced strobes for this opcode.

## Interface
- `LD_OPCODE`, default 5'b00000: opcode value accepted as `ld`.
- `MEM_TIMEOUT`, default 15: maximum cycles spent waiting for `mem_ready` in one memory read (range 1..255).
- `clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to run one load; sampled only in IDLE.
- `mem_ready`  in  1  memory read data valid on the memory output.
- `ir_opcode`  in  5  IR[31:27] from datapath; sampled in T4.
- `pco`, `mari`, `mem_read`, `mdri`, `mdro`, `iri`  out  1 each  datapath strobes.
- `grb`, `gra`, `baout`, `rin`, `ryi`, `csigno`, `rzli`, `rzlo`  out  1 each  datapath strobes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; Ra written this cycle.
- `fault`  out  2  00 none, 01 memory timeout, 10 illegal opcode; sticky.

## Operation
- Moore machine with a 4-bit registered state. Strobes are decoded from the state register only; there is no combinational path from any input to any output.
- States and the strobes asserted in each (all strobes not listed are 0):
  - IDLE: none. `start`=1 -> T0, clears `fault`.
  - T0: `pco`, `mari`. Next -> T1.
  - T1: `mem_read`. `mem_ready`=1 -> T2. Otherwise stay and count.
  - T2: `mem_read`, `mdri`. Next -> T3.
  - T3: `mdro`, `iri`. Next -> T4.
  - T4: no strobes (decode). `ir_opcode`==`LD_OPCODE` -> T5. Else -> FAULT with code 10.
  - T5: `grb`, `baout`, `ryi` (Y <- Rb, or 0 when Rb = R0). Next -> T6.
  - T6: `csigno`, `rzli` (Z <- Y + sext(C)). Next -> T7.
  - T7: `rzlo`, `mari`. Next -> T8.
  - T8: `mem_read`. `mem_ready`=1 -> T9. Otherwise stay and count.
  - T9: `mem_read`, `mdri`. Next -> T10.
  - T10: `mdro`, `gra`, `rin`, `done`. Next -> IDLE.
  - FAULT: no strobes. Next -> IDLE.
- Wait counter is 8 bits.
  - Zeroed on entry to T1 and T8.
  - Increments on each edge spent in T1/T8 with `mem_ready`=0.
  - When the count reaches `MEM_TIMEOUT` with `mem_ready` still 0 -> FAULT with code 01.
  - `mem_ready` has priority over timeout when both occur on the same edge.
- `fault` holds its code through IDLE until the next accepted `start`.
- `mem_ready` is ignored outside T1/T8. `start` is ignored outside IDLE, including a `start` held high through `done`.

## Timing
- Reset (`clear`=0, any time, including mid-sequence): state IDLE, counter 0, every strobe 0, `busy`=0, `done`=0, `fault`=00. Takes effect without waiting for a clock edge.
- `start` sampled high at edge k -> T0 during cycle k+1.
- With `mem_ready` tied high, each wait state lasts 1 cycle. `done` is high 11 cycles after the `start` edge (T0..T10), and `busy` is high for 11 cycles.
- Each cycle with `mem_ready` low in T1 or T8 adds 1 cycle of latency.
- Timeout: FAULT is entered on the edge where the count reaches `MEM_TIMEOUT`; the machine is in IDLE one cycle later.
- The datapath captures on the rising edge at the end of the strobe cycle:
  - MDR is loaded at the end of T2/T9.
  - IR is loaded at the end of T3, so `ir_opcode` is stable in T4.
- Back-to-back loads: `start` high in the IDLE cycle after T10 gives T0 on the next edge; IDLE lasts a minimum of 1 cycle.

## Test plan
- Normal load:
  - Stimulus: `mem_ready`=1; mem[0] = ld R2, 0x10(R1); R1 = 0x20; mem[0x30] = 0xDEADBEEF.
  - Response: `done` in cycle 11; R2 = 0xDEADBEEF; `fault`=00; strobe sequence matches the state list cycle-for-cycle.
- R0 base:
  - Stimulus: ld R3, 0x7C(R0) with R0 = 0x55 and mem[0x7C] = 0x1234.
  - Response: R3 = 0x1234, because `baout` forces 0 on the bus.
- Negative offset and memory waits:
  - Stimulus: C = -4 (0x7FFFC), Rb = 0x40; `mem_ready` low for 3 cycles in T8.
  - Response: MAR = 0x3C; `done` at cycle 14.
- Timeout:
  - Stimulus: `mem_ready` stuck at 0 in T1, `MEM_TIMEOUT`=15.
  - Response: FAULT after 15 wait cycles, `fault`=01, IDLE next cycle, no `rin`. A subsequent `start` clears `fault` to 00.
- Illegal opcode:
  - Stimulus: IR opcode 5'b00010.
  - Response: T4 -> FAULT, `fault`=10, and no `ryi`/`rin` ever asserted.
- Reset mid-operation:
  - Stimulus: `clear` low asynchronously during T6, then released, then `start`.
  - Response: all outputs 0 immediately; the next `start` runs a clean full sequence; `start` pulses issued during `busy` are ignored.
